serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 23 ++
 rtl/serial_subtractor_if.sv | 42 ++++
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter width helper.
package serial_sub_pkg;

  // Operand/result width used when the instantiating level does not override it.
  localparam int unsigned DefaultWidth = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  // The result is floored at one bit so that a counter always exists.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/result bundle for serial_subtractor.
// With SERIAL_SUB_OVF_EN defined, the bundle also carries the signed-overflow flag v.
// master: the requester. slave: the subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             v;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done, v
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done, v
  );
`else
  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
`endif

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: o_d = i_a - i_b - i_bin (mod 2).
// o_bout is the borrow from the next bit position.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin, LSB first, one bit per clock.
// A single full_subtractor cell is reused across every bit position.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output v.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Bits produced so far. The incoming bit enters at the top, so after WIDTH
  // steps bit 0 sits at the bottom of w_res_next.
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_SUB_OVF_EN
  // The shift registers lose the operand MSBs, so keep them for the overflow flag.
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_v;
`endif

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;

  full_subtractor u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // Shift the new bit in at the top of the partial result.
  assign w_res_next = {w_d, r_res};
  assign w_accept   = bus.start && (r_state == StIdle || r_state == StDone);

  // Controller, operand shifters and registered result in one FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_v     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
`endif
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          // start is ignored here: no queueing and no restart.
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_res_next[WIDTH-1:1];
          r_br  <= w_bout;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastBit) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
`ifdef SERIAL_SUB_OVF_EN
            r_v     <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.v    = r_v;
`endif

endmodule
